// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Types and constants shared by the pipeline front-end stages.
//               Holds the address/instruction widths, the default reset PC,
//               the canonical NOP encoding and the instr/PC pair type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] INSTR_NOP        = 32'h0000_0013;

  // One entry as presented to Stage1Fetch.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_pair_t;

endpackage
`default_nettype wire

// File: rtl/stage0_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module      : stage0_prefetch_if
// Description : Bundles the prefetch stage's instruction-memory port, its
//               fetch-side valid/ready port and the decode redirect input.
// Ports       : master - the prefetch stage (drives requests and the head)
//               slave  - the environment (memory, fetch and decode)
// Revision    : 1.0 - initial release
// ============================================================================
interface stage0_prefetch_if #(
  parameter int ADDR_W = pipeline_pkg::ADDR_W
);
  import pipeline_pkg::*;

  // instruction-memory request / response
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_resp_valid;
  logic [INSTR_W-1:0] mem_resp_data;

  // towards Stage1Fetch
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;

  // redirect from Stage2Decode
  logic               jump_enable;
  logic [ADDR_W-1:0]  jump_address;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  jump_enable, jump_address
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output jump_enable, jump_address
  );

endinterface
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_fifo
// Description : Synchronous FIFO with a single-cycle flush. The head word is
//               read straight from the storage registers, so it is always a
//               registered value. Storage is reset so the head reads 0 after
//               reset.
// Ports       : clk, rst_n    - clock, asynchronous active-low reset
//               flush_i       - empty the FIFO; overrides push/pop this cycle
//               push_i/_data  - write at the tail (ignored when full)
//               pop_i         - advance the head (ignored when empty)
//               head_o        - current head word
//               empty_o/full_o/count_o - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i  && (count_q != '0);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/stage0_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : stage0_prefetch
// Description : Instruction prefetch queue feeding Stage1Fetch. Issues
//               sequential word-aligned reads, pairs each in-order response
//               with the PC recorded at issue, and presents the queue head
//               on a valid/ready port. A jump flushes the queue, marks all
//               in-flight reads for discard and restarts at the target.
// Ports       : clk, rst_n - clock, asynchronous active-low reset
//               bus_io     - stage0_prefetch_if.master (memory request and
//                            response, fetch valid/ready/instr/pc, jump)
// Revision    : 1.0 - initial release
// ============================================================================
module stage0_prefetch #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = pipeline_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = pipeline_pkg::RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  stage0_prefetch_if.master bus_io
);
  import pipeline_pkg::*;

  localparam int                CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] START_PC  = {RESET_PC[ADDR_W-1:2], 2'b00};

  logic                      en_q;
  logic [ADDR_W-1:0]         fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]          outstanding_q, outstanding_d;
  logic [CNT_W-1:0]          drop_q, drop_d;

  logic                      q_empty, q_full;
  logic [CNT_W-1:0]          q_count;
  logic [INSTR_W+ADDR_W-1:0] q_head;
  logic                      pc_empty, pc_full;
  logic [CNT_W-1:0]          pc_count;
  logic [ADDR_W-1:0]         pc_head;

  logic                      flush;
  logic                      req_valid;
  logic                      req_hs;
  logic                      resp_drop;
  logic                      resp_keep;
  logic                      deq;

  assign flush = bus_io.jump_enable;

  // Credit: every queued entry and every read in flight owns a slot, so a
  // response always finds room. en_q holds requests off while in reset.
  assign req_valid = en_q && !flush &&
                     (({1'b0, q_count} + {1'b0, outstanding_q}) < DEPTH_EXT);
  assign req_hs    = req_valid && bus_io.mem_req_ready;

  // A response in the flush cycle is stale even when drop_q is still 0.
  assign resp_drop = bus_io.mem_resp_valid && (flush || (drop_q != '0));
  assign resp_keep = bus_io.mem_resp_valid && !resp_drop;
  assign deq       = !q_empty && bus_io.instr_ready && !flush;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CNT_W'(req_hs) - CNT_W'(bus_io.mem_resp_valid);
    drop_d        = drop_q;
    if (flush) begin
      fetch_pc_d = {bus_io.jump_address[ADDR_W-1:2], 2'b00};
      // Everything still in flight after this cycle belongs to the old stream.
      drop_d     = outstanding_d;
    end else begin
      if (req_hs) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (resp_drop) begin
        drop_d = drop_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q          <= 1'b0;
      fetch_pc_q    <= START_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      en_q          <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // PCs of live (non-dropped) reads, in issue order.
  prefetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (req_hs),
    .push_data_i (fetch_pc_q),
    .pop_i       (resp_keep),
    .head_o      (pc_head),
    .empty_o     (pc_empty),
    .full_o      (pc_full),
    .count_o     (pc_count)
  );

  // {instr, pc} entries waiting for fetch.
  prefetch_fifo #(
    .WIDTH (INSTR_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (resp_keep),
    .push_data_i ({bus_io.mem_resp_data, pc_head}),
    .pop_i       (deq),
    .head_o      (q_head),
    .empty_o     (q_empty),
    .full_o      (q_full),
    .count_o     (q_count)
  );

  assign bus_io.mem_req_valid = req_valid;
  assign bus_io.mem_req_addr  = fetch_pc_q;
  assign bus_io.instr_valid   = !q_empty;
  assign bus_io.instr         = q_head[INSTR_W+ADDR_W-1:ADDR_W];
  assign bus_io.instr_pc      = q_head[ADDR_W-1:0];

  // Protocol and bookkeeping invariants.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
                    resp_keep |-> !q_full);
  a_resp_expect : assert property (@(posedge clk) disable iff (!rst_n)
                    bus_io.mem_resp_valid |-> (outstanding_q != '0));
  a_pc_avail    : assert property (@(posedge clk) disable iff (!rst_n)
                    resp_keep |-> !pc_empty);
  a_pc_room     : assert property (@(posedge clk) disable iff (!rst_n)
                    req_hs |-> !pc_full);
  a_pc_track    : assert property (@(posedge clk) disable iff (!rst_n)
                    pc_count == (outstanding_q - drop_q));

endmodule
`default_nettype wire

// File: tb/tb_stage0_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage0_prefetch
// Description : Self-checking bench for stage0_prefetch. A memory model
//               answers reads in order with configurable latency; a stream
//               model checks that requests and deliveries each follow the
//               sequential PC stream restarted at every jump target.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage0_prefetch;
  import pipeline_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stage0_prefetch_if #(.ADDR_W(32)) bus   ();
  stage0_prefetch_if #(.ADDR_W(32)) bus_b ();

  stage0_prefetch #(.DEPTH(DEPTH), .ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .bus_io(bus));

  stage0_prefetch #(.DEPTH(DEPTH), .ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus_io(bus_b));

  typedef struct { int due; logic [31:0] addr; } mreq_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  mreq_t mq[$];
  int last_due = 0;
  int lat_min = 1, lat_max = 1;

  logic [31:0] exp_req, exp_pc, prev_addr;
  int live;
  bit prev_jump, prev_pend;

  bit          s_req_valid, s_req_hs, s_instr_valid, s_del_hs;
  logic [31:0] s_req_addr, s_instr_pc, s_instr;

  bit          b_prev_hs = 0;
  logic [31:0] b_addrs[$];

  function automatic logic [31:0] memf(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  // One clock: drive memory response, sample at +1, run stream model, wait
  // for the next falling edge. Entered and left on a falling edge.
  task automatic tick();
    int          due;
    mreq_t       m;
    bit          jmp;
    logic [31:0] tgt;
    bit          b_hs;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = memf(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = $urandom;
    end
    bus_b.mem_resp_valid = b_prev_hs;
    bus_b.mem_resp_data  = 32'h0;
    #1;
    jmp           = bus.jump_enable;
    tgt           = {bus.jump_address[31:2], 2'b00};
    s_req_valid   = bus.mem_req_valid;
    s_req_addr    = bus.mem_req_addr;
    s_instr_valid = bus.instr_valid;
    s_instr_pc    = bus.instr_pc;
    s_instr       = bus.instr;
    s_req_hs      = s_req_valid && bus.mem_req_ready;
    s_del_hs      = s_instr_valid && bus.instr_ready && !jmp;

    if (jmp) begin
      n_cmp++;
      if (s_req_valid !== 1'b0) begin
        n_err++; $display("FAIL req_during_jump: cyc %0d mem_req_valid=%b want 0", cyc, s_req_valid);
      end
    end
    if (prev_jump) begin
      n_cmp++;
      if (s_instr_valid !== 1'b0) begin
        n_err++; $display("FAIL valid_after_jump: cyc %0d instr_valid=%b want 0", cyc, s_instr_valid);
      end
    end
    if (prev_pend && !jmp) begin
      n_cmp++;
      if (s_req_valid !== 1'b1 || s_req_addr !== prev_addr) begin
        n_err++; $display("FAIL req_stable: cyc %0d valid=%b addr=%h want 1/%h", cyc, s_req_valid, s_req_addr, prev_addr);
      end
    end
    if (s_req_hs) begin
      n_cmp++;
      if (s_req_addr !== exp_req) begin
        n_err++; $display("FAIL req_addr: cyc %0d addr=%h want %h", cyc, s_req_addr, exp_req);
      end
      exp_req = exp_req + 32'd4;
      live++;
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      m.due = due; m.addr = s_req_addr;
      mq.push_back(m);
    end
    if (s_del_hs) begin
      n_cmp++;
      if (s_instr_pc !== exp_pc || s_instr !== memf(exp_pc)) begin
        n_err++; $display("FAIL delivery: cyc %0d pc=%h instr=%h want %h/%h", cyc, s_instr_pc, s_instr, exp_pc, memf(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      live--;
    end
    if (jmp) begin
      exp_req = tgt; exp_pc = tgt; live = 0;
    end
    n_cmp++;
    if (live > DEPTH) begin
      n_err++; $display("FAIL credit: cyc %0d live entries %0d exceed %0d", cyc, live, DEPTH);
    end
    prev_jump = jmp;
    prev_pend = s_req_valid && !bus.mem_req_ready && !jmp;
    prev_addr = s_req_addr;

    b_hs = bus_b.mem_req_valid && bus_b.mem_req_ready;
    if (b_hs && b_addrs.size() < 4) b_addrs.push_back(bus_b.mem_req_addr);
    b_prev_hs = b_hs;

    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.jump_enable = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus_b.mem_resp_valid = 1'b0;
    mq.delete();
    b_prev_hs = 0;
    exp_req = 32'h0; exp_pc = 32'h0; live = 0;
    prev_jump = 0; prev_pend = 0;
    repeat (2) @(negedge clk);
    cyc += 2;
    last_due = cyc;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.mem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valids: req=%b instr=%b want 0/0", bus.mem_req_valid, bus.instr_valid);
    end
    n_cmp++;
    if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
      n_err++; $display("FAIL reset_head: instr=%h pc=%h want 0/0", bus.instr, bus.instr_pc);
    end
    n_cmp++;
    if (bus.mem_req_addr !== 32'h0 || bus_b.mem_req_addr !== 32'hFFFF_FFF8) begin
      n_err++; $display("FAIL reset_addr: a=%h b=%h want 0/fffffff8", bus.mem_req_addr, bus_b.mem_req_addr);
    end
    do_reset();
  endtask

  task automatic test_sequential();
    int first_req = -1, first_val = -1;
    logic [31:0] pcs[$];
    int c;
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 14; i++) begin
      c = cyc;
      tick();
      if (s_req_hs && first_req < 0) first_req = c;
      if (s_instr_valid && first_val < 0) first_val = c;
      if (s_del_hs && pcs.size() < 3) pcs.push_back(s_instr_pc);
    end
    n_cmp++;
    if (first_req < 0 || first_val - first_req != 2) begin
      n_err++; $display("FAIL first_latency: req cyc %0d valid cyc %0d want gap 2", first_req, first_val);
    end
    n_cmp++;
    if (pcs.size() != 3) begin
      n_err++; $display("FAIL seq_count: got %0d deliveries want 3", pcs.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (pcs[k] !== 32'(4 * k)) begin
          n_err++; $display("FAIL seq_pc%0d: got %h want %h", k, pcs[k], 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_reset_pc_wrap();
    logic [31:0] want[4];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0; want[3] = 32'h4;
    n_cmp++;
    if (b_addrs.size() != 4) begin
      n_err++; $display("FAIL wrap_count: got %0d requests want 4", b_addrs.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (b_addrs[k] !== want[k]) begin
          n_err++; $display("FAIL wrap_addr%0d: got %h want %h", k, b_addrs[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int n_hs = 0;
    logic [31:0] last_addr = 32'hX;
    logic [31:0] first_after = 32'hX;
    bit got_after = 0;
    logic [31:0] pcs[$];
    do_reset();
    lat_min = 1; lat_max = 1;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_req_hs) begin n_hs++; last_addr = s_req_addr; end
    end
    n_cmp++;
    if (n_hs != DEPTH || last_addr !== 32'hC || s_req_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_fill: hs=%0d last=%h valid=%b want 4/c/0", n_hs, last_addr, s_req_valid);
    end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_req_hs && !got_after) begin got_after = 1; first_after = s_req_addr; end
      if (s_del_hs && pcs.size() < 4) pcs.push_back(s_instr_pc);
    end
    n_cmp++;
    if (!got_after || first_after !== 32'h10) begin
      n_err++; $display("FAIL stall_resume: addr=%h want 10", first_after);
    end
    n_cmp++;
    if (pcs.size() != 4 || pcs[0] !== 32'h0 || pcs[3] !== 32'hC) begin
      n_err++; $display("FAIL stall_drain: count=%0d want 4 pcs 0..c", pcs.size());
    end
  endtask

  task automatic test_jump_drop();
    int n_hs = 0;
    bit got = 0;
    logic [31:0] first_pc = 32'hX;
    do_reset();
    lat_min = 3; lat_max = 3;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 10 && n_hs < 2; i++) begin
      tick();
      if (s_req_hs) n_hs++;
    end
    bus.jump_enable = 1'b1; bus.jump_address = 32'h103;
    tick();
    bus.jump_enable = 1'b0;
    tick();
    n_cmp++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
      n_err++; $display("FAIL jump_restart: valid=%b addr=%h want 1/100", s_req_valid, s_req_addr);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_del_hs && !got) begin got = 1; first_pc = s_instr_pc; end
    end
    n_cmp++;
    if (!got || first_pc !== 32'h100) begin
      n_err++; $display("FAIL jump_first_pc: got %h want 100", first_pc);
    end
  endtask

  task automatic test_jump_collide();
    int n_hs = 0;
    bit got = 0;
    logic [31:0] first_pc = 32'hX;
    do_reset();
    lat_min = 2; lat_max = 2;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 10 && n_hs < 2; i++) begin
      tick();
      if (s_req_hs) n_hs++;
    end
    // The first response lands in the jump cycle; the second is in flight.
    bus.jump_enable = 1'b1; bus.jump_address = 32'h200;
    tick();
    bus.jump_enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_del_hs && !got) begin got = 1; first_pc = s_instr_pc; end
    end
    n_cmp++;
    if (!got || first_pc !== 32'h200) begin
      n_err++; $display("FAIL collide_first_pc: got %h want 200", first_pc);
    end
  endtask

  task automatic test_random();
    int n_del = 0;
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 600; i++) begin
      bus.mem_req_ready = ($urandom % 4) != 0;
      bus.instr_ready   = ($urandom % 3) != 0;
      bus.jump_enable   = ($urandom % 20) == 0;
      bus.jump_address  = $urandom;
      tick();
      if (s_del_hs) n_del++;
    end
    bus.jump_enable = 1'b0; bus.mem_req_ready = 1'b1; bus.instr_ready = 1'b1;
    n_cmp++;
    if (n_del < 50) begin
      n_err++; $display("FAIL random_progress: %0d deliveries want at least 50", n_del);
    end
  endtask

  task automatic test_async_reset();
    bit got_req = 0, got_del = 0;
    logic [31:0] req0 = 32'hX, pc0 = 32'hX;
    do_reset();
    lat_min = 3; lat_max = 3;
    bus.instr_ready = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin
      n_err++; $display("FAIL async_valids: req=%b instr=%b want 0/0", bus.mem_req_valid, bus.instr_valid);
    end
    n_cmp++;
    if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 || bus.mem_req_addr !== 32'h0) begin
      n_err++; $display("FAIL async_values: instr=%h pc=%h addr=%h want 0/0/0", bus.instr, bus.instr_pc, bus.mem_req_addr);
    end
    @(negedge clk);
    cyc++;
    do_reset();
    lat_min = 1; lat_max = 1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_req_hs && !got_req) begin got_req = 1; req0 = s_req_addr; end
      if (s_del_hs && !got_del) begin got_del = 1; pc0 = s_instr_pc; end
    end
    n_cmp++;
    if (!got_req || req0 !== 32'h0 || !got_del || pc0 !== 32'h0) begin
      n_err++; $display("FAIL async_restart: req=%h pc=%h want 0/0", req0, pc0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.mem_req_ready = 1'b1;   bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 32'h0;
    bus.instr_ready = 1'b1;     bus.jump_enable = 1'b0;    bus.jump_address = 32'h0;
    bus_b.mem_req_ready = 1'b1; bus_b.mem_resp_valid = 1'b0; bus_b.mem_resp_data = 32'h0;
    bus_b.instr_ready = 1'b1;   bus_b.jump_enable = 1'b0;  bus_b.jump_address = 32'h0;
    exp_req = 32'h0; exp_pc = 32'h0; live = 0; prev_jump = 0; prev_pend = 0;
    test_reset();
    test_sequential();
    test_reset_pc_wrap();
    test_stall();
    test_jump_drop();
    test_jump_collide();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
